led_pattern_gen: RTL
====================

// Module: led_pattern_gen
// PURPOSE
//  Parametrised LED pattern engine driving the board LED bank from SYSCLK.
//  Generalises the fixed 8-LED rotator: configurable width and step period,
//  four run-time modes, speed scaling, pause/single-step, and a step tick out.
//  Sits at the top level between SYSCLK and the LED pins.
// PARAMETERS
//  WIDTH   8         number of LEDs (>=1)
//  PERIOD  25000000  SYSCLK cycles per step at SPEED=0 (20ns*25e6 = 500ms)
// PORTS
//  SYSCLK  in   1      system clock (50 MHz)
//  RST_N   in   1      asynchronous active-low reset
//  MODE    in   2      0 rotate-left, 1 rotate-right, 2 bounce, 3 binary count
//  SPEED   in   3      step period = max(PERIOD >> SPEED, 1) cycles
//  PAUSE   in   1      1 = hold pattern and prescaler
//  STEP    in   1      1-cycle pulse; advances one step while PAUSE=1
//  BRIGHT  in   4      brightness duty; used only with LED_PWM_EN
//  LED     out  WIDTH  LED drive, bit 0 = first LED
//  TICK    out  1      1-cycle pulse on every pattern advance
// BEHAVIOUR
//  Reset (RST_N=0, async): pattern=1 (one-hot bit 0), dir=left, prescaler=0,
//   mode_q=0, TICK=0; LED = pattern (PWM gating applies when enabled).
//  Prescaler: cnt counts 0..lim-1, lim = max(PERIOD>>SPEED, 1); adv when
//   cnt==lim-1 and PAUSE=0, then cnt<=0. SPEED change mid-count: if cnt>=new
//   lim-1, advance on next cycle and clear.
//  PAUSE=1: cnt held. STEP=1 && PAUSE=1 -> adv that cycle. STEP with PAUSE=0
//   ignored.
//  Advance (registered; pattern/TICK update on the edge after adv):
//   mode0: pattern <= {p[W-2:0],p[W-1]}; mode1: {p[0],p[W-1:1]}
//   mode2: one-hot moves toward dir; at bit W-1 dir<=right, at bit 0
//          dir<=left; the end LED shows one step only (0..W-1..0, period
//          2W-2). WIDTH=1: stays 1.
//   mode3: pattern <= pattern+1, wraps all-ones -> 0.
//  TICK = 1 for exactly the cycle after each advance.
//  Mode change (MODE != mode_q): next edge mode_q<=MODE, cnt<=0, dir<=left,
//   pattern <= 1 (modes 0-2) or 0 (mode 3), TICK=0. Reload beats a
//   coincident adv/STEP.
//  Reset mid-operation: all state returns to reset values immediately.
//  MODE, SPEED, PAUSE, STEP are synchronous to SYSCLK (no synchronisers here).
// CONFIGURATION
//  LED_PWM_EN defined: 4-bit free-running pwm counter; gate = (pwm < BRIGHT)
//   || (BRIGHT==15); LED = pattern & {WIDTH{gate}}. BRIGHT=0 -> all LEDs off.
//   Pattern/TICK timing unchanged.
//  LED_PWM_EN undefined: LED = pattern; BRIGHT unused (port kept).
// STRUCTURE
//  Shared package led_pattern_pkg: MODE_ROTL=0, MODE_ROTR=1, MODE_BOUNCE=2,
//   MODE_COUNT=3; DIR_LEFT/DIR_RIGHT.
//  Sub-module led_tick_gen: prescaler (PERIOD, SPEED, PAUSE, STEP -> adv).
//   Pattern/mode logic and PWM stay in led_pattern_gen.
// TESTING (PERIOD=4, WIDTH=8 unless stated)
//  1 Reset, MODE=0, SPEED=0: LED 01->02->04..80->01, one step per 4 cycles,
//    TICK 1-cycle pulse per step.
//  2 MODE=2: LED 01,02..80,40..01,02; 80 and 01 each held 1 step; WIDTH=1
//    stays 1.
//  3 MODE=3: count 00..FF, FF->00 wrap; SPEED=2 -> one step every cycle
//    (lim=1).
//  4 PAUSE=1 for 20 cycles: LED frozen, no TICK; STEP pulse -> one advance +
//    TICK; STEP with PAUSE=0 no extra step.
//  5 MODE 0->3 on adv cycle: pattern 00, cnt cleared, no TICK; RST_N low
//    mid-bounce -> LED=01 at once.
//  6 LED_PWM_EN, BRIGHT=4: each lit LED on 4 of every 16 cycles;
//    BRIGHT=15 always on; BRIGHT=0 off.

Source files
------------

// File: rtl/led_pattern_pkg.sv
// led_pattern_pkg -- shared constants and helpers for the LED pattern engine.
//   MODE_*   : run-time pattern mode encodings (value of the MODE input)
//   DIR_*    : bounce direction encodings
//   step_limit(): prescaler limit for a given base period and speed shift
package led_pattern_pkg;

  localparam logic [1:0] MODE_ROTL   = 2'd0;
  localparam logic [1:0] MODE_ROTR   = 2'd1;
  localparam logic [1:0] MODE_BOUNCE = 2'd2;
  localparam logic [1:0] MODE_COUNT  = 2'd3;

  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

  // Cycles per step: period >> speed, never below one cycle.
  function automatic logic [31:0] step_limit(input logic [31:0] period,
                                             input logic [2:0]  speed);
    logic [31:0] shifted;
    shifted = period >> speed;
    if (shifted == 32'd0) begin
      return 32'd1;
    end else begin
      return shifted;
    end
  endfunction

endpackage

// File: rtl/led_tick_gen.sv
// led_tick_gen -- step prescaler for the LED pattern engine.
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : synchronous clear of the count (mode reload); suppresses adv
//   speed      : limit = max(PERIOD >> speed, 1)
//   pause      : hold the count; while set, step requests an advance
//   step       : single-step request, honoured only while paused
//   adv        : combinational advance request for the current cycle
module led_tick_gen
  import led_pattern_pkg::*;
#(
  parameter int unsigned PERIOD = 25000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic [2:0] speed,
  input  logic       pause,
  input  logic       step,
  output logic       adv
);

  localparam int unsigned CW = (PERIOD > 1) ? $clog2(PERIOD) : 1;

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic [31:0]   lim_m1_s;
  logic          at_end_s;

  // Next count and advance request. ">=" rather than "==" so a speed-up that
  // leaves the count beyond the new limit still advances on the next cycle.
  always_comb begin
    lim_m1_s = step_limit(32'(PERIOD), speed) - 32'd1;
    at_end_s = (32'(cnt_q) >= lim_m1_s);
    cnt_d    = cnt_q;
    adv      = 1'b0;
    if (clr) begin
      cnt_d = '0;
      adv   = 1'b0;
    end else if (pause) begin
      cnt_d = cnt_q;
      adv   = step;
    end else if (at_end_s) begin
      cnt_d = '0;
      adv   = 1'b1;
    end else begin
      cnt_d = cnt_q + CW'(1'b1);
      adv   = 1'b0;
    end
  end

  // Prescaler count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/led_pattern_gen.sv
// led_pattern_gen -- parametrised LED pattern engine.
//   SYSCLK  : system clock
//   RST_N   : asynchronous active-low reset
//   MODE    : 0 rotate-left, 1 rotate-right, 2 bounce, 3 binary count
//   SPEED   : step period = max(PERIOD >> SPEED, 1) cycles
//   PAUSE   : hold pattern and prescaler
//   STEP    : one-cycle pulse, advances one step while PAUSE=1
//   BRIGHT  : PWM duty (only with LED_PWM_EN defined)
//   LED     : LED drive, bit 0 = first LED
//   TICK    : one-cycle pulse in the cycle after each advance
// Optional feature macro: LED_PWM_EN (brightness gating of LED).
module led_pattern_gen
  import led_pattern_pkg::*;
#(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned PERIOD = 25000000
) (
  input  logic             SYSCLK,
  input  logic             RST_N,
  input  logic [1:0]       MODE,
  input  logic [2:0]       SPEED,
  input  logic             PAUSE,
  input  logic             STEP,
  input  logic [3:0]       BRIGHT,
  output logic [WIDTH-1:0] LED,
  output logic             TICK
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic [WIDTH-1:0] pattern_q, pattern_d, step_next_s;
  logic             dir_q, dir_d, dir_next_s;
  logic [1:0]       mode_q, mode_d;
  logic             tick_q, tick_d;
  logic             mode_chg_s;
  logic             adv_s;

  assign mode_chg_s = (MODE != mode_q);

  led_tick_gen #(
    .PERIOD (PERIOD)
  ) u_tick_gen (
    .clk   (SYSCLK),
    .rst_n (RST_N),
    .clr   (mode_chg_s),
    .speed (SPEED),
    .pause (PAUSE),
    .step  (STEP),
    .adv   (adv_s)
  );

  // Pattern one step ahead in the current mode. Rotations are written as
  // shift/or pairs so WIDTH=1 degenerates to "stay" without a bad slice.
  always_comb begin
    step_next_s = pattern_q;
    dir_next_s  = dir_q;
    case (mode_q)
      MODE_ROTL: step_next_s = (pattern_q << 1) | (pattern_q >> (WIDTH - 1));
      MODE_ROTR: step_next_s = (pattern_q >> 1) | (pattern_q << (WIDTH - 1));
      MODE_BOUNCE: begin
        if (WIDTH == 1) begin
          step_next_s = pattern_q;
        end else if (dir_q == DIR_LEFT) begin
          step_next_s = pattern_q << 1;
          // Turn as soon as the end LED is reached so it is shown one step.
          if (step_next_s[WIDTH-1]) begin
            dir_next_s = DIR_RIGHT;
          end else begin
            dir_next_s = dir_q;
          end
        end else begin
          step_next_s = pattern_q >> 1;
          if (step_next_s[0]) begin
            dir_next_s = DIR_LEFT;
          end else begin
            dir_next_s = dir_q;
          end
        end
      end
      MODE_COUNT: step_next_s = pattern_q + ONE;
      default:    step_next_s = pattern_q;
    endcase
  end

  // State update; a mode reload takes priority over a coincident advance.
  always_comb begin
    mode_d    = mode_q;
    pattern_d = pattern_q;
    dir_d     = dir_q;
    tick_d    = 1'b0;
    if (mode_chg_s) begin
      mode_d    = MODE;
      pattern_d = (MODE == MODE_COUNT) ? '0 : ONE;
      dir_d     = DIR_LEFT;
      tick_d    = 1'b0;
    end else if (adv_s) begin
      pattern_d = step_next_s;
      dir_d     = dir_next_s;
      tick_d    = 1'b1;
    end else begin
      pattern_d = pattern_q;
      dir_d     = dir_q;
      tick_d    = 1'b0;
    end
  end

  // Pattern, direction, mode and tick registers.
  always_ff @(posedge SYSCLK or negedge RST_N) begin
    if (!RST_N) begin
      pattern_q <= ONE;
      dir_q     <= DIR_LEFT;
      mode_q    <= MODE_ROTL;
      tick_q    <= 1'b0;
    end else begin
      pattern_q <= pattern_d;
      dir_q     <= dir_d;
      mode_q    <= mode_d;
      tick_q    <= tick_d;
    end
  end

  assign TICK = tick_q;

`ifdef LED_PWM_EN
  logic [3:0] pwm_q, pwm_d;
  logic       gate_s;

  // Free-running PWM phase; independent of PAUSE so brightness never freezes.
  always_comb begin
    pwm_d  = pwm_q + 4'd1;
    gate_s = (pwm_q < BRIGHT) || (BRIGHT == 4'd15);
  end

  // PWM phase register.
  always_ff @(posedge SYSCLK or negedge RST_N) begin
    if (!RST_N) begin
      pwm_q <= 4'd0;
    end else begin
      pwm_q <= pwm_d;
    end
  end

  assign LED = pattern_q & {WIDTH{gate_s}};
`else
  logic unused_bright_s;
  assign unused_bright_s = ^BRIGHT;
  assign LED = pattern_q;
`endif

endmodule
